// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer: state encoding,
// key-length codes, round counts and the Go/Ry vector bit positions.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARK,
    ST_SBT,
    ST_SHR,
    ST_MXC,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_RSV = 2'b11;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  localparam int unsigned GO_ARK = 0;
  localparam int unsigned GO_SBT = 1;
  localparam int unsigned GO_SHR = 2;
  localparam int unsigned GO_MXC = 3;
  localparam int unsigned GO_W   = 4;

  // Number of rounds for a key length; the reserved code maps to 0.
  function automatic int unsigned nr_of(input logic [1:0] keylen);
    case (keylen)
      KL_128:  return NR_128;
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_stage_timer.sv
// Per-stage watchdog: counts cycles spent in a stage and flags when the
// count has reached the timeout limit.
module aes_stage_timer #(
  parameter int unsigned TMR_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  assign o_expired = (r_count == TMR_W'(TIMEOUT));

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128/192/256 round controller: walks the ARK/SBT/SHR/MXC stages in cipher
// or inverse-cipher order with a Go/Ry handshake, watchdog and abort.
module aes_round_sequencer #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned KEYSEL_W = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TMR_W    = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  input  logic                Abort,
  input  logic [1:0]          KeyLen,
  input  logic                Decrypt,
  input  logic [DATA_W-1:0]   PT,
  output logic [DATA_W-1:0]   Text,
  output logic [DATA_W-1:0]   CT,
  output logic                Go_ARK,
  output logic                Go_SBT,
  output logic                Go_SHR,
  output logic                Go_MXC,
  input  logic                Ry_ARK,
  input  logic                Ry_SBT,
  input  logic                Ry_SHR,
  input  logic                Ry_MXC,
  input  logic [DATA_W-1:0]   Text_ARK,
  input  logic [DATA_W-1:0]   Text_SBT,
  input  logic [DATA_W-1:0]   Text_SHR,
  input  logic [DATA_W-1:0]   Text_MXC,
  output logic                Inv,
  output logic [KEYSEL_W-1:0] KeySel,
  output logic                Busy,
  output logic                Ry,
  output logic                Err
);

  import aes_seq_pkg::*;

  seq_state_e          r_state;
  logic [1:0]          r_keylen;
  logic                r_inv;
  logic [KEYSEL_W-1:0] r_keysel;
  logic [DATA_W-1:0]   r_text;
  logic [DATA_W-1:0]   r_ct;
  logic [GO_W-1:0]     r_go;
  logic                r_busy;
  logic                r_ry;
  logic                r_err;

  logic                w_in_stage;
  logic                w_first;
  logic                w_stage_ry;
  logic [DATA_W-1:0]   w_stage_text;
  logic                w_cap;
  logic                w_start;
  logic                w_expired;
  logic                w_timeout;
  logic                w_tmr_clr;
  logic [KEYSEL_W-1:0] w_nr;

  assign w_in_stage = (r_state inside {ST_ARK, ST_SBT, ST_SHR, ST_MXC});
  assign w_first    = |r_go;
  assign w_nr       = KEYSEL_W'(nr_of(r_keylen));
  assign w_start    = Start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});

  // Select the handshake of the active stage only; other Ry inputs are ignored.
  always_comb begin
    w_stage_ry   = 1'b0;
    w_stage_text = r_text;
    case (r_state)
      ST_ARK: begin w_stage_ry = Ry_ARK; w_stage_text = Text_ARK; end
      ST_SBT: begin w_stage_ry = Ry_SBT; w_stage_text = Text_SBT; end
      ST_SHR: begin w_stage_ry = Ry_SHR; w_stage_text = Text_SHR; end
      ST_MXC: begin w_stage_ry = Ry_MXC; w_stage_text = Text_MXC; end
      default: ;
    endcase
  end

  // Ry is not accepted in the Go cycle, giving every stage at least two cycles.
  assign w_cap     = w_in_stage && !w_first && w_stage_ry;
  assign w_timeout = w_in_stage && w_expired && !w_cap;
  assign w_tmr_clr = !w_in_stage || w_cap;

  aes_stage_timer #(
    .TMR_W   (TMR_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (Clk),
    .i_rst_n   (Rst_n),
    .i_clr     (w_tmr_clr),
    .i_en      (w_in_stage),
    .o_expired (w_expired)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= ST_IDLE;
      r_keylen <= KL_128;
      r_inv    <= 1'b0;
      r_keysel <= '0;
      r_text   <= '0;
      r_ct     <= '0;
      r_go     <= '0;
      r_busy   <= 1'b0;
      r_ry     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_go <= '0;
      if (Abort) begin
        r_state  <= ST_IDLE;
        r_keysel <= '0;
        r_busy   <= 1'b0;
        r_ry     <= 1'b0;
        r_err    <= 1'b0;
      end else if (w_start) begin
        r_keylen <= KeyLen;
        r_inv    <= Decrypt;
        r_text   <= PT;
        r_ry     <= 1'b0;
        if (KeyLen == KL_RSV) begin
          r_state  <= ST_ERR;
          r_keysel <= '0;
          r_busy   <= 1'b0;
          r_err    <= 1'b1;
        end else begin
          r_state      <= ST_ARK;
          r_go[GO_ARK] <= 1'b1;
          r_keysel     <= Decrypt ? KEYSEL_W'(nr_of(KeyLen)) : '0;
          r_busy       <= 1'b1;
          r_err        <= 1'b0;
        end
      end else if (w_timeout) begin
        r_state <= ST_ERR;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end else if (w_cap) begin
        r_text <= w_stage_text;
        r_ct   <= w_stage_text;
        case (r_state)
          ST_ARK: begin
            if ((!r_inv && r_keysel == w_nr) || (r_inv && r_keysel == '0)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_ry    <= 1'b1;
            end else if (!r_inv) begin
              r_keysel     <= r_keysel + KEYSEL_W'(1);
              r_state      <= ST_SBT;
              r_go[GO_SBT] <= 1'b1;
            end else if (r_keysel == w_nr) begin
              r_keysel     <= r_keysel - KEYSEL_W'(1);
              r_state      <= ST_SHR;
              r_go[GO_SHR] <= 1'b1;
            end else begin
              r_state      <= ST_MXC;
              r_go[GO_MXC] <= 1'b1;
            end
          end
          ST_SBT: begin
            if (r_inv) begin
              r_state      <= ST_ARK;
              r_go[GO_ARK] <= 1'b1;
            end else begin
              r_state      <= ST_SHR;
              r_go[GO_SHR] <= 1'b1;
            end
          end
          ST_SHR: begin
            if (r_inv) begin
              r_state      <= ST_SBT;
              r_go[GO_SBT] <= 1'b1;
            end else if (r_keysel == w_nr) begin
              r_state      <= ST_ARK;
              r_go[GO_ARK] <= 1'b1;
            end else begin
              r_state      <= ST_MXC;
              r_go[GO_MXC] <= 1'b1;
            end
          end
          ST_MXC: begin
            if (r_inv) begin
              r_keysel     <= r_keysel - KEYSEL_W'(1);
              r_state      <= ST_SHR;
              r_go[GO_SHR] <= 1'b1;
            end else begin
              r_state      <= ST_ARK;
              r_go[GO_ARK] <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign Text   = r_text;
  assign CT     = r_ct;
  assign Go_ARK = r_go[GO_ARK];
  assign Go_SBT = r_go[GO_SBT];
  assign Go_SHR = r_go[GO_SHR];
  assign Go_MXC = r_go[GO_MXC];
  assign Inv    = r_inv;
  assign KeySel = r_keysel;
  assign Busy   = r_busy;
  assign Ry     = r_ry;
  assign Err    = r_err;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed/randomised bench for aes_round_sequencer with XOR stage stubs and a
// stage-list reference model built directly from the round rules.
module tb_aes_round_sequencer;

  localparam int unsigned DW = 128;
  localparam int unsigned KW = 4;
  localparam int unsigned TO = 255;
  localparam int unsigned TW = 8;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic [1:0]    KeyLen = 2'b00;
  logic          Decrypt = 1'b0;
  logic [DW-1:0] PT = '0;
  logic [DW-1:0] Text, CT;
  logic          Go_ARK, Go_SBT, Go_SHR, Go_MXC;
  logic          Ry_ARK = 1'b0, Ry_SBT = 1'b0, Ry_SHR = 1'b0, Ry_MXC = 1'b0;
  logic [DW-1:0] Text_ARK = '0, Text_SBT = '0, Text_SHR = '0, Text_MXC = '0;
  logic          Inv;
  logic [KW-1:0] KeySel;
  logic          Busy, Ry, Err;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned go_cnt = 0;
  int unsigned multi_go = 0;
  logic          hold_en = 1'b0;
  logic [KW-1:0] hold_ks = '0;
  logic [3:0]    pend = '0;
  logic [DW-1:0] base = '0;
  logic [KW-1:0] ks_s = '0;
  logic [5:0]    mon_q[$];
  logic [5:0]    exp_q[$];

  aes_round_sequencer #(.DATA_W(DW), .KEYSEL_W(KW), .TIMEOUT(TO), .TMR_W(TW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort), .KeyLen(KeyLen),
    .Decrypt(Decrypt), .PT(PT), .Text(Text), .CT(CT),
    .Go_ARK(Go_ARK), .Go_SBT(Go_SBT), .Go_SHR(Go_SHR), .Go_MXC(Go_MXC),
    .Ry_ARK(Ry_ARK), .Ry_SBT(Ry_SBT), .Ry_SHR(Ry_SHR), .Ry_MXC(Ry_MXC),
    .Text_ARK(Text_ARK), .Text_SBT(Text_SBT), .Text_SHR(Text_SHR), .Text_MXC(Text_MXC),
    .Inv(Inv), .KeySel(KeySel), .Busy(Busy), .Ry(Ry), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Stage codes: 0 ARK, 1 SBT, 2 SHR, 3 MXC. ARK mixes in a per-round key.
  function automatic logic [DW-1:0] stage_key(input logic [1:0] code, input logic [KW-1:0] ks);
    logic [7:0] b;
    b = 8'h6E ^ {4'h0, ks};
    case (code)
      2'd0:    return {16{b}};
      2'd1:    return {4{32'hA5A5_0F0F}};
      2'd2:    return {4{32'h1234_5678}};
      default: return {4{32'h0BAD_F00D}};
    endcase
  endfunction

  function automatic int unsigned rounds(input logic [1:0] kl);
    return (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
  endfunction

  // Stub stages: a Go seen in one cycle is answered with Ry for the following cycle.
  always begin
    @(negedge Clk);
    pend = {Go_MXC, Go_SHR, Go_SBT, Go_ARK};
    if (hold_en && Go_SBT && KeySel == hold_ks) pend[1] = 1'b0;
    base = Text;
    ks_s = KeySel;
    @(posedge Clk);
    #1;
    Ry_ARK = pend[0]; Ry_SBT = pend[1]; Ry_SHR = pend[2]; Ry_MXC = pend[3];
    Text_ARK = base ^ stage_key(2'd0, ks_s);
    Text_SBT = base ^ stage_key(2'd1, ks_s);
    Text_SHR = base ^ stage_key(2'd2, ks_s);
    Text_MXC = base ^ stage_key(2'd3, ks_s);
  end

  always @(negedge Clk) begin
    if (Rst_n && (Go_ARK || Go_SBT || Go_SHR || Go_MXC)) begin
      if ($countones({Go_ARK, Go_SBT, Go_SHR, Go_MXC}) != 1) multi_go++;
      go_cnt++;
      mon_q.push_back({Go_ARK ? 2'd0 : Go_SBT ? 2'd1 : Go_SHR ? 2'd2 : 2'd3, KeySel});
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected stage list (code, round-key index) straight from the round rules.
  task automatic build(input logic [1:0] kl, input logic dec);
    int nr;
    nr = int'(rounds(kl));
    exp_q.delete();
    if (!dec) begin
      exp_q.push_back({2'd0, 4'(0)});
      for (int r = 1; r <= nr; r++) begin
        exp_q.push_back({2'd1, 4'(r)});
        exp_q.push_back({2'd2, 4'(r)});
        if (r < nr) exp_q.push_back({2'd3, 4'(r)});
        exp_q.push_back({2'd0, 4'(r)});
      end
    end else begin
      exp_q.push_back({2'd0, 4'(nr)});
      for (int r = nr - 1; r >= 0; r--) begin
        if (r < nr - 1) exp_q.push_back({2'd3, 4'(r + 1)});
        exp_q.push_back({2'd2, 4'(r)});
        exp_q.push_back({2'd1, 4'(r)});
        exp_q.push_back({2'd0, 4'(r)});
      end
    end
  endtask

  function automatic logic [DW-1:0] fold(input logic [DW-1:0] pt, input int upto);
    logic [DW-1:0] t;
    t = pt;
    for (int i = 0; i < upto; i++) t = t ^ stage_key(exp_q[i][5:4], exp_q[i][3:0]);
    return t;
  endfunction

  function automatic int find_stage(input logic [5:0] s);
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i] == s) return i;
    return 0;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] kl, input logic dec,
                        input logic [DW-1:0] pt, input bit busy_start);
    int n;
    int inv_bad;
    int nr;
    nr = int'(rounds(kl));
    build(kl, dec);
    mon_q.delete();
    KeyLen = kl; Decrypt = dec; PT = pt; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk({tag, "_go_ark0"}, DW'(Go_ARK), DW'(1));
    chk({tag, "_busy0"}, DW'(Busy), DW'(1));
    n = 0;
    inv_bad = 0;
    while (!Ry && n < 2000) begin
      tick();
      n++;
      if (Busy && Inv !== dec) inv_bad++;
      if (busy_start && n == 30) begin
        Start = 1'b1; KeyLen = 2'b11; Decrypt = ~dec; PT = ~pt;
      end
      if (busy_start && n == 31) Start = 1'b0;
    end
    chk({tag, "_latency"}, DW'(n), DW'(8 * nr));
    chk({tag, "_ct"}, CT, fold(pt, exp_q.size()));
    chk({tag, "_text"}, Text, fold(pt, exp_q.size()));
    chk({tag, "_inv_hold"}, DW'(inv_bad), DW'(0));
    chk({tag, "_inv"}, DW'(Inv), DW'(dec));
    chk({tag, "_keysel_end"}, DW'(KeySel), dec ? DW'(0) : DW'(nr));
    chk({tag, "_flags_done"}, DW'({Busy, Err}), DW'(0));
    chk({tag, "_seq_len"}, DW'(mon_q.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk($sformatf("%s_seq%0d", tag, i), DW'(mon_q[i]), DW'(exp_q[i]));
    tick();
    chk({tag, "_done_hold"}, DW'(Ry), DW'(1));
  endtask

  initial begin
    logic [DW-1:0] pt;
    int m;
    int gc;
    repeat (2) tick();
    chk("rst_text", Text, '0);
    chk("rst_ct", CT, '0);
    chk("rst_ctl", DW'({Go_ARK, Go_SBT, Go_SHR, Go_MXC, Busy, Ry, Err, Inv, KeySel}), DW'(0));
    Rst_n = 1'b1;
    repeat (2) tick();

    // Encrypt AES-128 with an ignored Start (reserved key length) mid-run.
    run_op("enc128", 2'b00, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    // Restart from DONE: decrypt AES-256.
    run_op("dec256", 2'b10, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Watchdog: SBT of round 3 never answers.
    pt = {$urandom, $urandom, $urandom, $urandom};
    build(2'b00, 1'b0);
    hold_en = 1'b1; hold_ks = 4'd3;
    KeyLen = 2'b00; Decrypt = 1'b0; PT = pt; Start = 1'b1;
    tick();
    Start = 1'b0;
    m = 0;
    while (!(Go_SBT && KeySel == 4'd3) && m < 200) begin tick(); m++; end
    chk("wd_reach_sbt3", DW'(Go_SBT && KeySel == 4'd3), DW'(1));
    m = 0;
    while (!Err && m < 1000) begin tick(); m++; end
    chk("wd_err_delay", DW'(m), DW'(TO + 1));
    chk("wd_busy", DW'(Busy), DW'(0));
    chk("wd_text", Text, fold(pt, find_stage({2'd1, 4'd3})));
    hold_en = 1'b0;
    repeat (3) tick();
    chk("wd_err_hold", DW'(Err), DW'(1));
    run_op("dec192", 2'b01, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Reserved key length goes straight to ERR without any Go.
    gc = int'(go_cnt);
    KeyLen = 2'b11; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("rsv_err", DW'({Err, Busy, Ry}), DW'(3'b100));
    repeat (3) tick();
    chk("rsv_nogo", DW'(go_cnt), DW'(gc));

    // Abort coinciding with Ry_MXC of round 1.
    pt = {$urandom, $urandom, $urandom, $urandom};
    build(2'b00, 1'b0);
    KeyLen = 2'b00; Decrypt = 1'b0; PT = pt; Start = 1'b1;
    tick();
    Start = 1'b0;
    m = 0;
    while (!Go_MXC && m < 50) begin tick(); m++; end
    chk("abort_reach_mxc", DW'(Go_MXC), DW'(1));
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_flags", DW'({Busy, Ry, Err}), DW'(0));
    chk("abort_text", Text, fold(pt, find_stage({2'd3, 4'd1})));
    chk("abort_ct", CT, fold(pt, find_stage({2'd3, 4'd1})));
    chk("abort_keysel", DW'(KeySel), DW'(0));
    gc = int'(go_cnt);
    repeat (4) tick();
    chk("abort_idle", DW'(go_cnt), DW'(gc));

    // Asynchronous reset between edges in the middle of a run.
    KeyLen = 2'b10; Decrypt = 1'b1; PT = {$urandom, $urandom, $urandom, $urandom}; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (20) tick();
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_text", Text, '0);
    chk("arst_ct", CT, '0);
    chk("arst_ctl", DW'({Go_ARK, Go_SBT, Go_SHR, Go_MXC, Busy, Ry, Err, Inv, KeySel}), DW'(0));
    tick();
    Rst_n = 1'b1;
    gc = int'(go_cnt);
    repeat (5) tick();
    chk("arst_idle", DW'({Busy, Ry, Err}), DW'(0));
    chk("arst_nogo", DW'(go_cnt), DW'(gc));
    chk("onehot_go", DW'(multi_go), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Parametrised successor to the AES-128 encrypt-only round controller. Sequences the AddRoundKey, SubBytes, ShiftRows and MixColumns datapath blocks for AES-128/192/256 in either encrypt or decrypt order, using a one-cycle Go / Ry handshake per stage. Drives the round-key index to the key schedule and adds a per-stage watchdog and an abort input. Sits between the top-level host interface and the four transform blocks.

Parameters:
DATA_W, 128, state width in bits; the block must work for any DATA_W, and AES uses 128.
KEYSEL_W, 4, round-key index width; must be able to hold 14.
TIMEOUT, 255, maximum number of wait cycles per stage before an error is raised; must be at least 1.
TMR_W, 8, watchdog counter width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
Clk  in  1  clock; all state changes on the rising edge.
Rst_n  in  1  asynchronous, active-low reset.
Start  in  1  begin an operation; sampled only in IDLE, DONE or ERR.
Abort  in  1  synchronous return to IDLE from any state.
KeyLen  in  2  key length: 00 = 128 (NR=10), 01 = 192 (NR=12), 10 = 256 (NR=14), 11 = reserved.
Decrypt  in  1  0 = cipher order, 1 = inverse-cipher order.
PT  in  DATA_W  input block; loaded at Start.
Text  out  DATA_W  working state presented to all stages.
CT  out  DATA_W  result; copy of Text, updated on every capture.
Go_ARK, Go_SBT, Go_SHR, Go_MXC  out  1 each  one-cycle start pulse to the stage.
Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC  in  1 each  stage result valid.
Text_ARK, Text_SBT, Text_SHR, Text_MXC  in  DATA_W each  stage results.
Inv  out  1  latched Decrypt; selects the inverse transforms in the stages.
KeySel  out  KEYSEL_W  current round-key index.
Busy  out  1  high in any stage state.
Ry  out  1  done; high while in DONE.
Err  out  1  high while in ERR.

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE; Text, CT, KeySel and the round counter are all 0; every Go, Busy, Ry, Err and Inv output is 0.
- States: IDLE, ARK, SBT, SHR, MXC, DONE, ERR.
- Start acceptance (in IDLE, DONE or ERR):
  - Latch KeyLen and Decrypt, and set Text=PT.
  - KeyLen=11: go to ERR.
  - Otherwise go to ARK. KeySel starts at 0 for encrypt and at NR for decrypt.
- Stage handshake:
  - On the first cycle in a stage state, the matching Go is high for exactly one cycle.
  - The block waits for the matching Ry. On the rising edge where Ry is high, it captures the stage's Text into Text and CT, then transitions.
  - Ry from any stage other than the active one is ignored.
  - Minimum residency is 2 cycles per stage.
- Encrypt transitions:
  - ARK: if KeySel==NR go to DONE; else KeySel++ and go to SBT.
  - SBT goes to SHR.
  - SHR: if KeySel==NR go to ARK; else go to MXC.
  - MXC goes to ARK.
- Decrypt transitions:
  - ARK: if KeySel==0 go to DONE; if KeySel==NR, KeySel-- and go to SHR; else go to MXC.
  - MXC: KeySel-- and go to SHR.
  - SHR goes to SBT, and SBT goes to ARK.
- Stage counts: 4*NR stages in both directions, i.e. 40, 48 or 56.
- Watchdog:
  - Counter cleared on stage entry, incremented every wait cycle.
  - If it reaches TIMEOUT with no Ry, go to ERR; Text is left unchanged.
- Abort: takes priority over Ry and timeout. Next state is IDLE; Text and CT hold their values; KeySel is cleared to 0.
- Start while Busy is ignored.
- DONE and ERR hold until Start or Abort.
- Go, Busy, Ry and Err are registered outputs (no combinational path from the inputs).

Decomposition:
- Package aes_seq_pkg:
  - state enum;
  - KeyLen encodings;
  - NR constants 10/12/14;
  - function nr_of(KeyLen).
- One sub-module, aes_stage_timer: TMR_W counter with clear, enable and expired (== TIMEOUT) outputs; instantiated once.

Test Plan:
- Encrypt, AES-128, stubs respond with Ry one cycle after Go (stage Text = Text XOR stage id); Start at edge E0 -> Go sequence ARK,(SBT,SHR,MXC,ARK)x9,SBT,SHR,ARK; KeySel goes 0..10; Ry rises at E0+80; CT equals the model.
- Decrypt, AES-256 -> sequence ARK(14),SHR,SBT,ARK(13),MXC,...,SHR,SBT,ARK(0); 56 stages; Ry at E0+112; Inv=1 throughout.
- Stub withholds Ry_SBT in round 3, TIMEOUT=255 -> Err rises 255 wait cycles after the Go_SBT cycle; Busy=0; Text equals the round-3 SBT input; a later Start restarts and completes normally.
- KeyLen=11 with Start -> ERR on the next cycle; no Go pulses.
- Abort in the same cycle as Ry_MXC -> IDLE; Text is not updated; KeySel=0. Start during Busy is ignored; Start in DONE restarts with new PT.
- Rst_n asserted mid-round, asynchronously between edges -> all outputs go to their reset values immediately; after release the block stays in IDLE until Start.
